// File: rtl/dtmf_digit_controller.sv
// Sequences the tone lookup unit once per detector frame, debounces the per-frame
// tone codes into key presses and queues each accepted key in a FWFT digit FIFO.
module dtmf_digit_controller #(
    parameter int unsigned STABLE_FRAMES  = 3,
    parameter int unsigned RELEASE_FRAMES = 2,
    parameter int unsigned LUT_TIMEOUT    = 16,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        frame_valid_i,
    input  logic [5:0]  low_bin_i,
    input  logic [5:0]  high_bin_i,
    output logic        lut_reset_o,
    output logic        lut_enable_o,
    output logic [5:0]  lut_low_bin_o,
    output logic [5:0]  lut_high_bin_o,
    input  logic        lut_done_i,
    input  logic        lut_error_i,
    input  logic [15:0] lut_tone_i,
    output logic [3:0]  digit_o,
    output logic        digit_valid_o,
    input  logic        digit_ready_i,
    output logic        frame_drop_o,
    output logic        overflow_o
);
    localparam int unsigned BIN_W  = 6;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned STB_W  = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned REL_W  = $clog2(RELEASE_FRAMES + 1);
    localparam int unsigned TMR_W  = $clog2(LUT_TIMEOUT + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_LOOKUP = 2'd2,
        S_EVAL   = 2'd3
    } state_t;

    state_t              state_q;
    logic                lut_reset_q;
    logic                lut_enable_q;
    logic [BIN_W-1:0]    lut_low_q;
    logic [BIN_W-1:0]    lut_high_q;
    logic [TMR_W-1:0]    timer_q;
    logic                res_valid_q;
    logic [CODE_W-1:0]   res_code_q;
    logic [CODE_W-1:0]   cand_q,     cand_d;
    logic [STB_W-1:0]    stable_q,   stable_d;
    logic [REL_W-1:0]    rel_q,      rel_d;
    logic                reported_q, reported_d;
    logic                frame_drop_q;
    logic                overflow_q;

    logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                push_c;
    logic                pop_c;
    logic                full_c;
    logic                wr_c;

    // Debounce update for the result captured in the previous LOOKUP cycle.
    always_comb begin
        cand_d     = cand_q;
        stable_d   = stable_q;
        rel_d      = rel_q;
        reported_d = reported_q;
        if (res_valid_q) begin
            rel_d = '0;
            if (res_code_q == cand_q) begin
                if (stable_q < STB_W'(STABLE_FRAMES)) begin
                    stable_d = stable_q + STB_W'(1);
                end
            end else begin
                cand_d     = res_code_q;
                stable_d   = STB_W'(1);
                reported_d = 1'b0;
            end
        end else if (rel_q + REL_W'(1) == REL_W'(RELEASE_FRAMES)) begin
            stable_d   = '0;
            reported_d = 1'b0;
            rel_d      = '0;
        end else begin
            rel_d = rel_q + REL_W'(1);
        end
        push_c = (state_q == S_EVAL) && (stable_d == STB_W'(STABLE_FRAMES)) && !reported_d;
    end

    assign pop_c  = (count_q != '0) && digit_ready_i;
    assign full_c = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_c   = push_c && (!full_c || pop_c);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            lut_reset_q  <= 1'b0;
            lut_enable_q <= 1'b0;
            lut_low_q    <= '0;
            lut_high_q   <= '0;
            timer_q      <= '0;
            res_valid_q  <= 1'b0;
            res_code_q   <= '0;
            cand_q       <= '0;
            stable_q     <= '0;
            rel_q        <= '0;
            reported_q   <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            lut_reset_q  <= 1'b0;
            frame_drop_q <= frame_valid_i && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (frame_valid_i) begin
                        lut_low_q   <= low_bin_i;
                        lut_high_q  <= high_bin_i;
                        lut_reset_q <= 1'b1;
                        state_q     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    lut_enable_q <= 1'b1;
                    timer_q      <= '0;
                    state_q      <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (lut_done_i) begin
                        res_valid_q  <= !lut_error_i && (lut_tone_i < 16'd16);
                        res_code_q   <= lut_tone_i[CODE_W-1:0];
                        lut_enable_q <= 1'b0;
                        state_q      <= S_EVAL;
                    end else if (timer_q == TMR_W'(LUT_TIMEOUT - 1)) begin
                        res_valid_q  <= 1'b0;
                        lut_enable_q <= 1'b0;
                        state_q      <= S_EVAL;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_EVAL: begin
                    cand_q     <= cand_d;
                    stable_q   <= stable_d;
                    rel_q      <= rel_d;
                    reported_q <= reported_d || push_c;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock_i) begin
        if (wr_c) begin
            mem_q[wr_ptr_q] <= cand_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_c && !wr_c) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (push_c && full_c && !pop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign lut_reset_o    = lut_reset_q;
    assign lut_enable_o   = lut_enable_q;
    assign lut_low_bin_o  = lut_low_q;
    assign lut_high_bin_o = lut_high_q;
    assign digit_valid_o  = (count_q != '0);
    assign digit_o        = digit_valid_o ? mem_q[rd_ptr_q] : '0;
    assign frame_drop_o   = frame_drop_q;
    assign overflow_o     = overflow_q;
endmodule

// File: tb/tb_dtmf_digit_controller.sv
// Directed and randomized frame sequences for dtmf_digit_controller, checked against
// a key-press tracker and a bounded digit queue kept in the bench.
module tb_dtmf_digit_controller;
    localparam int STABLE  = 3;
    localparam int RELEASE = 2;
    localparam int TMO     = 16;
    localparam int DEPTH   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_valid = 1'b0;
    logic [5:0]  low_bin = '0;
    logic [5:0]  high_bin = '0;
    logic        lut_reset;
    logic        lut_enable;
    logic [5:0]  lut_low_bin;
    logic [5:0]  lut_high_bin;
    logic        lut_done = 1'b0;
    logic        lut_error = 1'b0;
    logic [15:0] lut_tone = 16'hFFFF;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        digit_ready = 1'b0;
    logic        frame_drop;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    // Key tracker: current key, how many matching frames in a row, how many misses in a row.
    int key_code, key_run, miss_run;
    bit key_sent, m_ovf;
    int m_q[$];

    dtmf_digit_controller #(
        .STABLE_FRAMES(STABLE), .RELEASE_FRAMES(RELEASE),
        .LUT_TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock_i(clock), .reset_i(reset), .frame_valid_i(frame_valid),
        .low_bin_i(low_bin), .high_bin_i(high_bin),
        .lut_reset_o(lut_reset), .lut_enable_o(lut_enable),
        .lut_low_bin_o(lut_low_bin), .lut_high_bin_o(lut_high_bin),
        .lut_done_i(lut_done), .lut_error_i(lut_error), .lut_tone_i(lut_tone),
        .digit_o(digit), .digit_valid_o(digit_valid), .digit_ready_i(digit_ready),
        .frame_drop_o(frame_drop), .overflow_o(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        key_code = 0; key_run = 0; miss_run = 0; key_sent = 1'b0; m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic model_frame(input bit valid, input int code, input bit pop_now);
        bit pushed;
        pushed = 1'b0;
        if (valid && code == key_code) begin
            key_run  = (key_run + 1 > STABLE) ? STABLE : key_run + 1;
            miss_run = 0;
        end else if (valid) begin
            key_code = code; key_run = 1; key_sent = 1'b0; miss_run = 0;
        end else begin
            miss_run++;
            if (miss_run >= RELEASE) begin
                key_run = 0; key_sent = 1'b0; miss_run = 0;
            end
        end
        if (pop_now && m_q.size() > 0) void'(m_q.pop_front());
        if (key_run == STABLE && !key_sent) begin
            key_sent = 1'b1;
            pushed = 1'b1;
        end
        if (pushed) begin
            if (m_q.size() < DEPTH) m_q.push_back(key_code);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_fifo(input string tag);
        chk({tag, "_valid"}, 32'(digit_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk({tag, "_head"}, 32'(digit), 32'(m_q[0]));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({lut_reset, lut_enable, lut_low_bin, lut_high_bin,
                      digit, digit_valid, frame_drop, overflow}), 32'd0);
    endtask

    // One complete frame: handshake timing checks, lookup response, debounce model update.
    task automatic do_frame(input logic [5:0] lo, input logic [5:0] hi, input logic [15:0] tone,
                            input bit err, input int lat, input bit tmo, input bit probe,
                            input bit pop_eval);
        int n;
        bit valid;
        frame_valid = 1'b1; low_bin = lo; high_bin = hi;
        step();
        frame_valid = 1'b0;
        chk("lut_reset_rise", 32'(lut_reset), 32'd1);
        chk("lut_bins", 32'({lut_low_bin, lut_high_bin}), 32'({lo, hi}));
        step();
        chk("lut_reset_fall", 32'(lut_reset), 32'd0);
        chk("lut_enable_rise", 32'(lut_enable), 32'd1);
        if (tmo) begin
            n = 1;
            while (lut_enable === 1'b1 && n <= TMO + 4) begin
                step();
                if (lut_enable === 1'b1) n++;
            end
            chk("timeout_len", 32'(n), 32'(TMO));
            valid = 1'b0;
        end else begin
            for (int i = 0; i < lat; i++) begin
                if (probe && i == 0) begin
                    frame_valid = 1'b1; low_bin = ~lo; high_bin = ~hi;
                end
                step();
                if (probe && i == 0) begin
                    frame_valid = 1'b0;
                    chk("frame_drop", 32'(frame_drop), 32'd1);
                    chk("bins_held", 32'(lut_low_bin), 32'(lo));
                end
                chk("enable_wait", 32'(lut_enable), 32'd1);
            end
            lut_done = 1'b1; lut_tone = tone; lut_error = err;
            step();
            lut_done = 1'b0; lut_error = 1'b0; lut_tone = 16'hFFFF;
            chk("enable_fall", 32'(lut_enable), 32'd0);
            valid = !err && (tone < 16);
        end
        digit_ready = pop_eval;
        step();
        digit_ready = 1'b0;
        model_frame(valid, int'(tone[3:0]), pop_eval);
        check_fifo("frame");
    endtask

    task automatic key(input logic [15:0] tone, input int frames);
        for (int i = 0; i < frames; i++) do_frame(6'd19, 6'd32, tone, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic miss(input int frames);
        for (int i = 0; i < frames; i++) do_frame(6'd1, 6'd2, 16'hFFFF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (m_q.size() > 0 && guard < 2 * DEPTH) begin
            chk({tag, "_valid"}, 32'(digit_valid), 32'd1);
            chk({tag, "_digit"}, 32'(digit), 32'(m_q[0]));
            digit_ready = 1'b1;
            step();
            digit_ready = 1'b0;
            void'(m_q.pop_front());
            guard++;
        end
        chk({tag, "_empty"}, 32'(digit_valid), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step();
        chk_all_zero(tag);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        step();
        do_reset("reset_state");

        // Three identical frames give one digit; a fourth gives nothing more.
        key(16'd1, 3);
        chk("one_digit_count", 32'(m_q.size()), 32'd1);
        key(16'd1, 1);
        drain("key1");

        // Two misses release the key; one miss is tolerated.
        key(16'd5, 3); miss(2); key(16'd5, 3);
        drain("release2");
        key(16'd5, 3); miss(1); key(16'd5, 3);
        drain("release1");

        // Candidate switch restarts the count.
        key(16'd1, 2); key(16'd10, 3);
        drain("switch");

        // Timeout is an invalid frame and must not push.
        do_frame(6'd19, 6'd32, 16'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("timeout_nopush", 32'(digit_valid), 32'd0);

        // Nine distinct keys with no consumer: eight kept, overflow sticky.
        do_reset("reset_pre_ovf");
        for (int k = 1; k <= 9; k++) key(16'(k), 3);
        chk("ovf_set", 32'(overflow), 32'd1);
        drain("ovf_order");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_reset("reset_ovf");

        // Push with simultaneous pop while full.
        for (int k = 1; k <= 8; k++) key(16'(k), 3);
        key(16'd9, 2);
        do_frame(6'd19, 6'd32, 16'd9, 1'b0, 2, 1'b0, 1'b0, 1'b1);
        chk("full_pushpop_ovf", 32'(overflow), 32'd0);
        drain("full_pushpop");

        // Frame arriving mid-lookup is dropped.
        do_frame(6'd20, 6'd33, 16'd2, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        chk("drop_clear", 32'(frame_drop), 32'd0);

        // Reset during LOOKUP with a digit queued.
        key(16'd7, 3);
        frame_valid = 1'b1; low_bin = 6'd3; high_bin = 6'd4;
        step();
        frame_valid = 1'b0;
        step();
        chk("in_lookup", 32'(lut_enable), 32'd1);
        do_reset("reset_lookup");
        step();
        chk("idle_after_reset", 32'(lut_enable), 32'd0);

        // Randomized frames from a small code set so that runs and releases occur.
        for (int f = 0; f < 60; f++) begin
            int sel;
            logic [15:0] tone;
            bit err;
            sel = int'($urandom_range(0, 5));
            err = 1'b0;
            case (sel)
                0: tone = 16'd1;
                1: tone = 16'd5;
                2: tone = 16'd10;
                3: tone = 16'd0;
                4: tone = 16'(16 + $urandom_range(0, 100));
                default: begin tone = 16'd5; err = ($urandom_range(0, 1) == 1); end
            endcase
            do_frame(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), tone, err,
                     int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), 1'b0,
                     ($urandom_range(0, 3) == 0));
            if (m_q.size() >= 6) drain("rand");
        end
        drain("rand_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dtmf_digit_controller.md
# dtmf_digit_controller

Sequences the DTMF tone lookup stage once per detector frame and debounces the per-frame results into clean key events. Each frame's low/high Goertzel bin indices go to the tone lookup unit through a clear/enable/done handshake. The resulting code is qualified over consecutive frames, and each accepted key press is pushed once into an output digit FIFO. The block sits between the Goertzel bin detector and the digit consumer (UART/display logic) in the control module.

## Interface
- STABLE_FRAMES, 3, consecutive identical valid frames required to accept a key (≥1)
- RELEASE_FRAMES, 2, consecutive invalid frames required to declare key release (≥1)
- LUT_TIMEOUT, 16, max cycles waiting for lut_done before the frame is declared invalid
- FIFO_DEPTH, 8, digit FIFO entries (power of two)
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- frame_valid  in  1  one-cycle pulse: low_bin/high_bin hold a new frame result
- low_bin, high_bin  in  6 each  detector bin indices for this frame
- lut_reset  out  1  clear pulse to lookup unit (flushes its done/error flags)
- lut_enable  out  1  lookup request
- lut_low_bin, lut_high_bin  out  6 each  registered bins driven to lookup unit
- lut_done, lut_error  in  1 each  lookup completion / invalid-bin flag
- lut_tone  in  16  tone code 0..15, 16'hFFFF = no tone
- digit  out  4  FIFO head tone code
- digit_valid  out  1  FIFO non-empty
- digit_ready  in  1  consumer pop; pop occurs when digit_valid && digit_ready
- frame_drop  out  1  one-cycle pulse: frame_valid arrived while not IDLE
- overflow  out  1  sticky: a digit was discarded because the FIFO was full

## Operation
- Reset values: every output 0; state IDLE; candidate code 0, stable count 0, release count 0, reported 0; FIFO empty.
- FSM states:
  - IDLE: on frame_valid, register bins into lut_*_bin and go to CLEAR.
  - CLEAR: lut_reset=1 for exactly one cycle, then go to LOOKUP.
  - LOOKUP: lut_enable=1 and wait timer counts. lut_done sampled high → EVAL with result captured. Timer reaching LUT_TIMEOUT → EVAL with result forced invalid.
  - EVAL: qualify the captured result, then return to IDLE.
- Frame result is valid iff lut_done && !lut_error && lut_tone != 16'hFFFF && lut_tone < 16. Timeout is invalid.
- EVAL, valid code equal to candidate: stable count increments, saturating at STABLE_FRAMES. Release count clears.
- EVAL, valid code different from candidate: candidate = code, stable count = 1, reported = 0, release count = 0.
- EVAL, invalid frame: release count increments. On reaching RELEASE_FRAMES: stable count = 0, reported = 0, release count = 0, candidate unchanged. Below the threshold, stable count is held (drop-out tolerance).
- Push: in EVAL, if the updated stable count == STABLE_FRAMES and reported == 0, push candidate[3:0] and set reported = 1. At most one push per key press.
- FIFO: first-word-fall-through.
  - Push when full without a simultaneous pop: digit discarded, overflow set; overflow clears only on reset.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
- frame_valid in any state other than IDLE: frame ignored, frame_drop pulses the next cycle.
- Reset mid-operation takes priority over everything. On the next edge: FSM returns to IDLE, FIFO is emptied, overflow is cleared.

## Timing
- frame_valid sampled at edge t: lut_reset high in cycle t+1, lut_enable high from t+2.
- lut_done first sampled at edge u: lut_enable low from u+1 (EVAL), FSM in IDLE at u+2.
- Pushed digit is visible on digit/digit_valid at u+2.
- Minimum frame period accepted without drops: 4 cycles plus the lookup latency.
- Timeout path: lut_enable stays high for exactly LUT_TIMEOUT cycles, then one EVAL cycle.
- digit_valid falls the cycle after the popping edge only if the FIFO becomes empty.

## Test plan
- Three frames (low 19, high 32), lut_tone=1 each → exactly one digit 1 after the third EVAL. A fourth identical frame → no further push.
- Frames: '5' ×3, invalid ×2, '5' ×3 → FIFO holds 5,5. Same sequence with a single invalid frame in the gap → only one 5.
- '1' ×2 then 'A' ×3 → only digit 10 pushed. Candidate switch resets the count.
- lut_done held 0 → lut_enable high for 16 cycles, frame treated invalid, FSM returns to IDLE, no push.
- digit_ready=0 with 9 distinct accepted keys → 8 entries, overflow=1. Then drain: order 1st..8th. Push-and-pop on a full FIFO → no overflow.
- frame_valid pulsed during LOOKUP → frame_drop pulse, frame ignored. reset asserted in LOOKUP → all outputs 0 next cycle, FIFO empty.
